// File: rtl/program_mem_loadable.sv
// program_mem_loadable: loadable instruction memory, 1-cycle fetch, bounds/alignment checks, streaming load port.
// Optional stored even parity per word under `define PROG_MEM_PARITY_EN.
module program_mem_loadable #(
  parameter int          DEPTH    = 128,
  parameter int          ADDR_W   = 32,
  parameter logic [31:0] NOP_WORD = 32'h00000013,
  parameter int          CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_valid,
  output logic [31:0]       fetch_data,
  output logic              fetch_err,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [31:0]       load_data,
  input  logic              load_last,
`ifdef PROG_MEM_PARITY_EN
  input  logic              parity_inject,
`endif
  output logic              load_ready,
  output logic              load_busy,
  output logic              load_done,
  output logic [CNT_W-1:0]  load_count
);
  localparam int PTR_W = $clog2(DEPTH);
`ifdef PROG_MEM_PARITY_EN
  localparam int MW = 33;
  localparam logic [MW-1:0] INIT_WORD = {^NOP_WORD, NOP_WORD};
`else
  localparam int MW = 32;
  localparam logic [MW-1:0] INIT_WORD = NOP_WORD;
`endif
  typedef enum logic {IDLE, LOAD} state_t;
  state_t            state, state_nx;
  logic [PTR_W-1:0]  ptr;
  logic [MW-1:0]     mem [DEPTH] = '{default: INIT_WORD};
  logic              wr, fin, oor, mis, perr;
  logic [ADDR_W-3:0] idx;
  logic [MW-1:0]     rd, wdata;
  always_comb begin
    wr       = state == LOAD && load_valid;
    fin      = wr && (load_last || ptr == PTR_W'(DEPTH - 1));
    state_nx = (state == IDLE) ? (load_start ? LOAD : IDLE) : (fin ? IDLE : LOAD);
  end
  assign load_ready = state == LOAD;
  assign load_busy  = state == LOAD;
  assign idx = fetch_addr[ADDR_W-1:2];
  assign oor = idx >= (ADDR_W-2)'(DEPTH);
  assign mis = |fetch_addr[1:0];
  assign rd  = mem[idx[PTR_W-1:0]];
`ifdef PROG_MEM_PARITY_EN
  // stored word plus parity bit must XOR to zero; inject flips the stored bit
  assign perr  = ^rd;
  assign wdata = {^load_data ^ parity_inject, load_data};
`else
  assign perr  = 1'b0;
  assign wdata = load_data;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr         <= '0;
      load_count  <= '0;
      load_done   <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data  <= NOP_WORD;
      fetch_err   <= 1'b0;
    end else begin
      load_done   <= fin;
      fetch_valid <= state == IDLE && fetch_req;
      if (state == IDLE && load_start) begin
        ptr        <= '0;
        load_count <= '0;
      end else if (wr) begin
        ptr        <= ptr + PTR_W'(1);
        load_count <= load_count + CNT_W'(1);
      end
      if (state == IDLE && fetch_req) begin
        fetch_data <= oor ? NOP_WORD : rd[31:0];
        fetch_err  <= oor | mis | perr;
      end
    end
  end
  // array has no reset so it can map onto block RAM
  always_ff @(posedge clk)
    if (wr) mem[ptr] <= wdata;
endmodule
